kbd_focus_arbiter: RTL and testbench
====================================

# kbd_focus_arbiter

Shares the single PS/2 keyboard decoder between two consumers: the game core (owner 0) and the menu/UI logic (owner 1). It sits directly after the keyboard decoder. It turns each decoder `key_valid` pulse into a make/break event, queues the events, and delivers each one to whichever consumer held focus when the event was captured. Focus hand-over is sequenced so that no consumer ever sees a break event without its matching make.

## Interface
Parameters:
- `DEPTH`, 8: event queue entries; must be a power of two, at least 2.
- `CNT_W`, 8: width of the dropped-event counter.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `key_valid`, input, 1: one-cycle event pulse from the keyboard decoder.
- `last_change`, input, 9: {extend, scan code} of the event.
- `key_down`, input, 512: held-key vector from the decoder. It is already updated in the same cycle that `key_valid` is high.
- `focus_req`, input, 1: single-cycle request to change focus.
- `focus_sel`, input, 1: requested owner; sampled when `focus_req` is high.
- `ev_data`, output, 10: {make, code9} at the queue head; shared by both consumers.
- `ev_valid`, output, 2: one-hot; bit i means the head event belongs to owner i.
- `ev_ready`, input, 2: per-consumer accept.
- `owner`, output, 1: current focus owner.
- `switching`, output, 1: high while a focus change is pending.
- `focus_ack`, output, 1: one-cycle pulse when the new owner takes effect.
- `drop_cnt`, output, CNT_W: count of events lost to a full queue; saturates.

## Operation
- Event capture, on each cycle with `key_valid`=1:
  - make = `key_down[last_change]`.
  - The entry {tag=owner, make, last_change} is pushed.
  - The tag is the owner at capture time, not at delivery.
- Queue:
  - DEPTH entries, circular, with log2(DEPTH)+1-bit read/write pointers.
  - full = pointers differ only in the MSB.
  - empty = pointers equal.
- Delivery:
  - When the queue is not empty, `ev_valid[tag]`=1 and the other bit is 0.
  - A pop happens when `ev_valid[i]` and `ev_ready[i]` are both 1.
  - The queue is strictly in order; a head event for an unready owner blocks later events for the other owner.
- Overflow:
  - A push while full with no pop in the same cycle is dropped, and `drop_cnt` increments, saturating at all-ones.
  - A push while full with a pop in the same cycle is accepted.
- Focus FSM, states RUN, DRAIN, SWAP:
  - RUN: `focus_req` with `focus_sel` != `owner` latches the target and moves to DRAIN. A request with `focus_sel` equal to `owner` is ignored.
  - DRAIN: `switching`=1. Capture continues, tagged with the old owner. Extra `focus_req` pulses are ignored. When `key_down` is all zero, move to SWAP.
  - SWAP: lasts one cycle. `owner` takes the target value, `focus_ack`=1, `switching` stays 1 for this cycle, then return to RUN.
  - An event captured in the SWAP cycle is tagged with the old owner.
- Events are never re-tagged. Entries already queued stay with their capture-time owner across a switch.

## Timing
- Reset values, asserted asynchronously while `rst_n`=0:
  - Queue empty, `ev_valid`=0, `ev_data`=0.
  - `owner`=0, FSM in RUN.
  - `switching`=0, `focus_ack`=0, `drop_cnt`=0.
- Reset in the middle of operation discards all queued events and any pending switch.
- Capture latency: `key_valid` in cycle N into an empty queue gives `ev_valid` and `ev_data` in cycle N+1.
- `ev_data` and `ev_valid` are driven combinationally from the registered queue head and `rd_ptr`. They are stable while not popped.
- A pop in cycle N presents the next entry in cycle N+1. Throughput is one event per cycle.
- Focus switch latency:
  - `focus_req` in cycle N: `switching` rises in N+1 (DRAIN).
  - The first cycle with `key_down`=0 in DRAIN is cycle M; SWAP occurs in M+1.
  - `owner` is updated and `switching` falls at M+2; `focus_ack` is high in M+1.
  - If `key_down` is already zero at N+1, `focus_ack` is high in N+2.
- `focus_req` during reset recovery or during SWAP is ignored.

## Structure
- Shared package `kbd_pkg`:
  - `EV_W`=10, `TAG_W`=1.
  - Owner constants `OWN_GAME`=0 and `OWN_MENU`=1.
  - FSM state encoding RUN/DRAIN/SWAP.
  - Entry layout {tag, make, code9}: bit 10 = tag, bit 9 = make, bits 8:0 = code.
- Sub-module `kbd_event_fifo`:
  - Parameterised DEPTH × (EV_W+TAG_W).
  - Push/pop, full/empty outputs, plus a drop pulse.
  - The arbiter holds the capture logic, routing, the FSM and `drop_cnt`.

## Test plan
- Press then release code 9'h01C with owner 0 and `ev_ready`=2'b01. Expect `ev_data`=10'h21C then 10'h01C. `ev_valid` is 2'b01 for each, one cycle after each `key_valid`.
- Hold 9'h11D (extended). `focus_req`=1 with `focus_sel`=1. Expect `switching`=1 and `owner` still 0. Release the key; the break 10'h11D is tagged owner 0. `focus_ack` pulses one cycle later, and `owner` is 1 on the following cycle.
- With `ev_ready`=0, inject 10 events at DEPTH=8. Expect 8 queued and `drop_cnt`=2. With full queue and push and pop in the same cycle, expect no drop.
- Head event tagged 0 with `ev_ready`=2'b10: the head stalls and an event tagged 1 behind it is not presented. Raising `ev_ready[0]` drains both in order.
- Assert `rst_n`=0 mid-DRAIN with 3 queued events. Expect all outputs at reset values immediately, `owner`=0, and the queue empty after release.
- `focus_req` with `focus_sel`=`owner`: no state change, no `focus_ack`.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard focus arbiter: entry layout, owners, FSM states.
package kbd_pkg;

    localparam int unsigned EV_W  = 10;
    localparam int unsigned TAG_W = 1;
    localparam int unsigned ENT_W = EV_W + TAG_W;

    localparam logic OWN_GAME = 1'b0;
    localparam logic OWN_MENU = 1'b1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StSwap  = 2'd2
    } focus_state_e;

    // Bit 10 = tag, bit 9 = make, bits 8:0 = {extend, scan code}.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             make;
        logic [8:0]       code;
    } entry_t;

    function automatic entry_t pack_entry(logic tag, logic make, logic [8:0] code);
        entry_t e;
        e.tag  = tag;
        e.make = make;
        e.code = code;
        return e;
    endfunction

endpackage

// File: rtl/kbd_focus_arbiter_if.sv
// Bundle between the keyboard decoder / consumers and the focus arbiter.
interface kbd_focus_arbiter_if
    import kbd_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic              key_valid;
    logic [8:0]        last_change;
    logic [511:0]      key_down;
    logic              focus_req;
    logic              focus_sel;
    logic [EV_W-1:0]   ev_data;
    logic [1:0]        ev_valid;
    logic [1:0]        ev_ready;
    logic              owner;
    logic              switching;
    logic              focus_ack;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  key_valid, last_change, key_down, focus_req, focus_sel, ev_ready,
        output ev_data, ev_valid, owner, switching, focus_ack, drop_cnt
    );

    modport master (
        output key_valid, last_change, key_down, focus_req, focus_sel, ev_ready,
        input  ev_data, ev_valid, owner, switching, focus_ack, drop_cnt
    );
endinterface

// File: rtl/kbd_event_fifo.sv
// Circular event queue with wrap-bit pointers; a push while full is accepted only alongside a pop.
module kbd_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_en;
    logic             w_wr_en;

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign w_pop_en = i_pop && !o_empty;
    assign w_wr_en  = i_push && (!o_full || w_pop_en);
    assign o_drop   = i_push && o_full && !w_pop_en;
    assign o_rdata  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Full-with-pop writes the slot being vacated this same edge.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/kbd_focus_arbiter.sv
// Tags decoder events with the current focus owner, queues them in order and sequences focus
// hand-over so a consumer never gets a break without its make.
module kbd_focus_arbiter
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    kbd_focus_arbiter_if.slave bus
);
    focus_state_e     r_state;
    logic             r_owner;
    logic             r_target;
    logic             r_switching;
    logic             r_focus_ack;
    logic [CNT_W-1:0] r_drop_cnt;

    entry_t           w_wr_entry;
    entry_t           w_head;
    logic [ENT_W-1:0] w_head_raw;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             w_pop;
    logic [1:0]       w_ev_valid;

    assign w_wr_entry = pack_entry(r_owner, bus.key_down[bus.last_change], bus.last_change);
    assign w_head     = entry_t'(w_head_raw);

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (bus.key_valid),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_ev_valid           = '0;
        w_ev_valid[OWN_GAME] = !w_empty && (w_head.tag == OWN_GAME);
        w_ev_valid[OWN_MENU] = !w_empty && (w_head.tag == OWN_MENU);
    end

    assign w_pop         = |(w_ev_valid & bus.ev_ready);
    assign bus.ev_valid  = w_ev_valid;
    assign bus.ev_data   = w_empty ? '0 : {w_head.make, w_head.code};
    assign bus.owner     = r_owner;
    assign bus.switching = r_switching;
    assign bus.focus_ack = r_focus_ack;
    assign bus.drop_cnt  = r_drop_cnt;

    // Waiting for key_down to clear guarantees every make already went to the old owner
    // together with its break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_owner     <= OWN_GAME;
            r_target    <= OWN_GAME;
            r_switching <= 1'b0;
            r_focus_ack <= 1'b0;
        end else begin
            r_focus_ack <= 1'b0;
            unique case (r_state)
                StRun: begin
                    if (bus.focus_req && (bus.focus_sel != r_owner)) begin
                        r_target    <= bus.focus_sel;
                        r_switching <= 1'b1;
                        r_state     <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus.key_down == '0) begin
                        r_focus_ack <= 1'b1;
                        r_state     <= StSwap;
                    end
                end
                StSwap: begin
                    r_owner     <= r_target;
                    r_switching <= 1'b0;
                    r_state     <= StRun;
                end
                default: r_state <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rst_n) w_drop |-> w_full);

endmodule

// File: tb/tb_kbd_focus_arbiter.sv
// Randomised and directed bench for kbd_focus_arbiter with a queue-based reference scoreboard.
module tb_kbd_focus_arbiter;
    import kbd_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          DROPMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       tag;
        logic [9:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kbd_focus_arbiter_if #(.CNT_W(CNT_W)) bus ();

    kbd_focus_arbiter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: ordered queue of expected events plus abstract focus bookkeeping.
    ev_t        exp_q[$];
    bit         m_owner, m_pending, m_target, m_ack;
    int         m_drop;
    logic [1:0] e_valid;
    logic [9:0] e_data;
    ev_t        e_new;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_owner   = 1'b0;
            m_pending = 1'b0;
            m_target  = 1'b0;
            m_ack     = 1'b0;
            m_drop    = 0;
        end else begin
            e_valid = 2'b00;
            e_data  = 10'h000;
            if (exp_q.size() > 0) begin
                e_valid = 2'b01 << exp_q[0].tag;
                e_data  = exp_q[0].data;
            end
            check("ev_valid", bus.ev_valid, e_valid);
            check("ev_data", bus.ev_data, e_data);
            check("owner", bus.owner, m_owner);
            check("switching", bus.switching, m_pending);
            check("focus_ack", bus.focus_ack, m_ack);
            check("drop_cnt", bus.drop_cnt, m_drop);
            if (exp_q.size() > 0 && bus.ev_ready[exp_q[0].tag]) void'(exp_q.pop_front());
            if (bus.key_valid) begin
                e_new.tag  = m_owner;
                e_new.data = {bus.key_down[bus.last_change], bus.last_change};
                if (exp_q.size() < DEPTH) exp_q.push_back(e_new);
                else if (m_drop < DROPMAX) m_drop++;
            end
            if (m_ack) begin
                m_owner   = m_target;
                m_pending = 1'b0;
                m_ack     = 1'b0;
            end else if (m_pending) begin
                if (bus.key_down == '0) m_ack = 1'b1;
            end else if (bus.focus_req && (bus.focus_sel != m_owner)) begin
                m_pending = 1'b1;
                m_target  = bus.focus_sel;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_event(input logic [8:0] code, input logic down);
        bus.key_down[code] = down;
        bus.last_change    = code;
        bus.key_valid      = 1'b1;
        tick();
        bus.key_valid      = 1'b0;
    endtask

    task automatic focus(input logic sel);
        bus.focus_req = 1'b1;
        bus.focus_sel = sel;
        tick();
        bus.focus_req = 1'b0;
    endtask

    logic [8:0] pool [6] = '{9'h01C, 9'h11D, 9'h05A, 9'h1F0, 9'h012, 9'h000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [8:0] code;
        bus.key_valid   = 1'b0;
        bus.last_change = '0;
        bus.key_down    = '0;
        bus.focus_req   = 1'b0;
        bus.focus_sel   = 1'b0;
        bus.ev_ready    = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ev_valid", bus.ev_valid, 0);
        check("rst_ev_data", bus.ev_data, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_switching", bus.switching, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Make then break delivered to owner 0.
        bus.ev_ready = 2'b01;
        key_event(9'h01C, 1'b1);
        @(negedge clk);
        check("t1_make_data", bus.ev_data, 10'h21C);
        check("t1_make_valid", bus.ev_valid, 2'b01);
        tick();
        key_event(9'h01C, 1'b0);
        @(negedge clk);
        check("t1_break_data", bus.ev_data, 10'h01C);
        check("t1_break_valid", bus.ev_valid, 2'b01);
        tick();

        // Focus change waits for the held extended key to be released.
        bus.ev_ready = 2'b11;
        key_event(9'h11D, 1'b1);
        tick();
        focus(1'b1);
        @(negedge clk);
        check("t2_switching", bus.switching, 1);
        check("t2_owner_old", bus.owner, 0);
        tick();
        tick();
        key_event(9'h11D, 1'b0);
        @(negedge clk);
        check("t2_break_data", bus.ev_data, 10'h11D);
        check("t2_break_tag0", bus.ev_valid, 2'b01);
        check("t2_focus_ack", bus.focus_ack, 1);
        tick();
        @(negedge clk);
        check("t2_owner_new", bus.owner, 1);
        check("t2_switch_done", bus.switching, 0);
        tick();

        // Overflow: 10 events into 8 entries, then a full push with a simultaneous pop.
        bus.ev_ready = 2'b00;
        for (int i = 0; i < 10; i++) key_event(9'h040 + 9'(i), 1'b1);
        @(negedge clk);
        check("t3_drop_cnt", bus.drop_cnt, 2);
        tick();
        bus.ev_ready = 2'b10;
        key_event(9'h050, 1'b1);
        bus.ev_ready = 2'b00;
        @(negedge clk);
        check("t3_no_drop_on_pop", bus.drop_cnt, 2);
        tick();
        bus.ev_ready = 2'b10;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ev_valid == 2'b10) cnt++;
        end
        check("t3_queued", cnt, 8);
        tick();
        bus.ev_ready = 2'b11;
        for (int i = 0; i < 10; i++) key_event(9'h040 + 9'(i), 1'b0);
        key_event(9'h050, 1'b0);
        repeat (2) tick();

        // Head-of-line blocking across owners.
        focus(1'b0);
        repeat (3) tick();
        bus.ev_ready = 2'b10;
        key_event(9'h021, 1'b1);
        focus(1'b1);
        tick();
        key_event(9'h021, 1'b0);
        tick();
        key_event(9'h022, 1'b1);
        @(negedge clk);
        check("t4_head_valid", bus.ev_valid, 2'b01);
        check("t4_head_data", bus.ev_data, 10'h221);
        repeat (3) tick();
        @(negedge clk);
        check("t4_still_stalled", bus.ev_valid, 2'b01);
        tick();
        bus.ev_ready = 2'b11;
        @(negedge clk);
        check("t4_drain0_data", bus.ev_data, 10'h221);
        tick();
        @(negedge clk);
        check("t4_drain1_data", bus.ev_data, 10'h021);
        check("t4_drain1_valid", bus.ev_valid, 2'b01);
        tick();
        @(negedge clk);
        check("t4_drain2_data", bus.ev_data, 10'h222);
        check("t4_drain2_valid", bus.ev_valid, 2'b10);
        tick();
        key_event(9'h022, 1'b0);
        repeat (2) tick();

        // Reset in the middle of DRAIN with events queued.
        bus.ev_ready = 2'b00;
        key_event(9'h030, 1'b1);
        key_event(9'h031, 1'b1);
        key_event(9'h032, 1'b1);
        focus(1'b0);
        @(negedge clk);
        check("t5_in_drain", bus.switching, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_ev_valid", bus.ev_valid, 0);
        check("t5_rst_ev_data", bus.ev_data, 0);
        check("t5_rst_owner", bus.owner, 0);
        check("t5_rst_switching", bus.switching, 0);
        check("t5_rst_focus_ack", bus.focus_ack, 0);
        check("t5_rst_drop_cnt", bus.drop_cnt, 0);
        bus.key_down = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_empty_after", bus.ev_valid, 0);
        tick();

        // Request for the current owner is ignored.
        focus(1'b0);
        @(negedge clk);
        check("t6_no_switch", bus.switching, 0);
        tick();
        @(negedge clk);
        check("t6_no_ack", bus.focus_ack, 0);
        check("t6_owner", bus.owner, 0);
        tick();

        // Random traffic, checked entirely by the scoreboard.
        for (int i = 0; i < 500; i++) begin
            bus.ev_ready = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) begin
                code = pool[$urandom_range(0, 5)];
                bus.key_down[code] = ~bus.key_down[code];
                bus.last_change    = code;
                bus.key_valid      = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.focus_req = 1'b1;
                bus.focus_sel = 1'($urandom_range(0, 1));
            end
            tick();
            bus.key_valid = 1'b0;
            bus.focus_req = 1'b0;
        end
        bus.ev_ready = 2'b11;
        for (int i = 0; i < 6; i++) begin
            code = pool[i];
            if (bus.key_down[code]) key_event(code, 1'b0);
        end
        repeat (30) tick();
        @(negedge clk);
        check("final_ev_valid", bus.ev_valid, 0);
        check("final_switching", bus.switching, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
